cursor_sprite_ctrl: RTL and testbench
=====================================

// Module: cursor_sprite_ctrl
// PURPOSE
//  Sequences the cursor sprite ROM for the VGA pixel pipeline. Holds the cursor position and accepts
//  move requests, committing them once per frame during vertical blank so the cursor never tears.
//  Generates the per-pixel sprite ROM address and a sprite_hit flag aligned with the ROM output
//  (ROM is clocked on the negedge of vga_clk, so its data is valid at the next posedge).
// PARAMETERS
//  SPR_W     24   sprite width in pixels
//  SPR_H     32   sprite height in pixels
//  H_ACTIVE  640  visible pixels per line
//  V_ACTIVE  480  visible lines per frame
//  DELTA_W   6    width of signed move_dx / move_dy
//  ADDR_W    10   ROM address width; must satisfy 2**ADDR_W >= SPR_W*SPR_H
//  INIT_X    308  cursor x after reset (top-left corner of the sprite)
//  INIT_Y    224  cursor y after reset
// PORTS
//  vga_clk      in   1        pixel clock; single clock domain
//  reset        in   1        synchronous, active-high
//  DrawX        in   10       current pixel column
//  DrawY        in   10       current pixel row
//  blank        in   1        1 = active display region
//  move_valid   in   1        move request valid
//  move_ready   out  1        move request accepted when valid & ready
//  move_dx      in   DELTA_W  signed x delta
//  move_dy      in   DELTA_W  signed y delta
//  rom_address  out  ADDR_W   sprite ROM address, registered
//  sprite_hit   out  1        registered; 1 = the current ROM output belongs to the sprite
//  pos_x        out  10       committed cursor x
//  pos_y        out  10       committed cursor y
// BEHAVIOUR
//  Reset: pos_x=INIT_X, pos_y=INIT_Y, rom_address=0, sprite_hit=0, pending deltas=0, state=ACCUM,
//   move_ready=1. Reset mid-commit abandons the commit and discards the pending deltas.
//  FSM ACCUM: on each move_valid&move_ready, add dx/dy into signed 11-bit pending_x/y, saturating
//   at +1023/-1024. vblank_rise = DrawY>=V_ACTIVE now and not in the previous cycle (registered
//   compare). vblank_rise -> COMMIT.
//  FSM COMMIT (1 cycle): move_ready=0. pos <= update(pos, pending). Pending cleared. -> ACCUM.
//  Simultaneous events: a move accepted in the vblank_rise cycle goes into the commit of that
//   same frame. No move is accepted in the COMMIT cycle.
//  Position update (default): clamp the result to x in [0, H_ACTIVE-SPR_W]=[0,616] and y in
//   [0, V_ACTIVE-SPR_H]=[0,448]. Compute in 12-bit signed arithmetic; negative results clamp to 0.
//  Pixel path, 1-cycle latency: ox=DrawX-pos_x and oy=DrawY-pos_y, each unsigned 10-bit.
//   in_box = blank & ox<SPR_W & oy<SPR_H & DrawX<H_ACTIVE. On the next posedge:
//   rom_address <= in_box ? oy*SPR_W+ox : 0; sprite_hit <= in_box.
//  Pixel-path boundaries: DrawX/DrawY to the left of or above pos wrap to a large unsigned
//   value, so in_box=0. The last sprite pixel maps to address SPR_W*SPR_H-1 = 767.
//  pos_x/pos_y change only at COMMIT, which falls inside vertical blank.
// CONFIGURATION
//  CURSOR_WRAP_EN defined: the update wraps instead of clamping. x is taken modulo H_ACTIVE and
//   y modulo V_ACTIVE; the sprite may be clipped at the right/bottom edges, with no wrap-around
//   drawing. Not defined: clamp as above.
// STRUCTURE
//  cursor_pkg: SPR_W/SPR_H/H_ACTIVE/V_ACTIVE default constants, the cursor_state_t enum
//   {ACCUM, COMMIT}, and the signed pending-delta typedef.
//  Sub-module cursor_pos_update: combinational clamp/wrap of pos+pending. It is the only place
//   the CURSOR_WRAP_EN macro is tested.
// TESTING
//  Reset, no moves: pos=(308,224). Pixel (308,224) with blank=1 -> next cycle rom_address=0,
//   sprite_hit=1. Pixel (331,255) -> rom_address=767.
//  move dx=+5,dy=-3 accepted at DrawY=100: pos unchanged until vblank_rise; one cycle after
//   COMMIT, pos=(313,221). move_ready=0 for exactly the COMMIT cycle.
//  Move accepted in the vblank_rise cycle: included in that frame's commit. Move with
//   move_valid held through COMMIT: accepted in the cycle after COMMIT, so it lands next frame.
//  Clamp: pos=(610,440), dx=+31,dy=+31 -> (616,448); dx=-32 from x=10 -> x=0.
//   CURSOR_WRAP_EN: x=630 with dx=+20 -> x=10.
//  Saturation: 40 moves of dx=+31 in one frame -> pending saturates at 1023; clamped x=616.
//  Pixel (307,224) or blank=0 -> sprite_hit=0, rom_address=0. Reset asserted during COMMIT:
//   pos=(308,224) and pending=0 afterwards.

Source files
------------

// File: rtl/cursor_pkg.sv
// cursor_pkg: shared constants, FSM state enum and pending-delta type for the cursor sprite controller
package cursor_pkg;
  localparam int DEF_SPR_W    = 24;
  localparam int DEF_SPR_H    = 32;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;
  typedef enum logic {ACCUM, COMMIT} cursor_state_t;
  typedef logic signed [10:0] pend_t;
endpackage

// File: rtl/cursor_pos_update.sv
// cursor_pos_update: pos+pending, clamped to the visible sprite range, or wrapped when CURSOR_WRAP_EN is defined
module cursor_pos_update
  import cursor_pkg::*;
#(
  parameter int SPR_W    = DEF_SPR_W,
  parameter int SPR_H    = DEF_SPR_H,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE
) (
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  input  pend_t      pend_x,
  input  pend_t      pend_y,
  output logic [9:0] new_x,
  output logic [9:0] new_y
);
  logic signed [11:0] sx, sy;
  assign sx = $signed({2'b00, pos_x}) + $signed({pend_x[10], pend_x});
  assign sy = $signed({2'b00, pos_y}) + $signed({pend_y[10], pend_y});
`ifdef CURSOR_WRAP_EN
  function automatic logic [9:0] wrap(input logic signed [11:0] v, input int m);
    int r;
    r = int'(v) % m;
    return 10'(r < 0 ? r + m : r);
  endfunction
  assign new_x = wrap(sx, H_ACTIVE);
  assign new_y = wrap(sy, V_ACTIVE);
`else
  localparam logic signed [11:0] X_MAX = 12'(H_ACTIVE - SPR_W);
  localparam logic signed [11:0] Y_MAX = 12'(V_ACTIVE - SPR_H);
  assign new_x = sx[11] ? '0 : sx > X_MAX ? X_MAX[9:0] : sx[9:0];
  assign new_y = sy[11] ? '0 : sy > Y_MAX ? Y_MAX[9:0] : sy[9:0];
`endif
endmodule

// File: rtl/cursor_sprite_ctrl.sv
// cursor_sprite_ctrl: cursor position with vblank-committed moves and sprite ROM addressing (CURSOR_WRAP_EN selects wrap)
module cursor_sprite_ctrl
  import cursor_pkg::*;
#(
  parameter int SPR_W    = DEF_SPR_W,
  parameter int SPR_H    = DEF_SPR_H,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int DELTA_W  = 6,
  parameter int ADDR_W   = 10,
  parameter int INIT_X   = 308,
  parameter int INIT_Y   = 224
) (
  input  logic                      vga_clk,
  input  logic                      reset,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  input  logic                      blank,
  input  logic                      move_valid,
  output logic                      move_ready,
  input  logic signed [DELTA_W-1:0] move_dx,
  input  logic signed [DELTA_W-1:0] move_dy,
  output logic [ADDR_W-1:0]         rom_address,
  output logic                      sprite_hit,
  output logic [9:0]                pos_x,
  output logic [9:0]                pos_y
);
  cursor_state_t state, state_nxt;
  pend_t pend_x, pend_y, pend_x_nxt, pend_y_nxt;
  logic vblank_d, vblank_rise, accept, in_box;
  logic [9:0] upd_x, upd_y, ox, oy;
  function automatic pend_t sat_add(input pend_t p, input logic signed [DELTA_W-1:0] d);
    logic [11:0] s;
    s = {p[10], p} + {{(12-DELTA_W){d[DELTA_W-1]}}, d};
    return (s[11] == s[10]) ? s[10:0] : s[11] ? 11'h400 : 11'h3FF;
  endfunction
  assign vblank_rise = (DrawY >= 10'(V_ACTIVE)) & ~vblank_d;
  assign move_ready  = state == ACCUM;
  assign accept      = move_valid & move_ready;
  assign ox          = DrawX - pos_x;
  assign oy          = DrawY - pos_y;
  assign in_box      = blank & (ox < 10'(SPR_W)) & (oy < 10'(SPR_H)) & (DrawX < 10'(H_ACTIVE));
  cursor_pos_update #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)
  ) u_upd (
    .pos_x(pos_x), .pos_y(pos_y), .pend_x(pend_x), .pend_y(pend_y), .new_x(upd_x), .new_y(upd_y)
  );
  // next state: accumulate moves until vblank starts, then spend one cycle committing
  always_comb begin
    state_nxt  = (state == COMMIT) ? ACCUM : vblank_rise ? COMMIT : ACCUM;
    pend_x_nxt = (state == COMMIT) ? '0 : accept ? sat_add(pend_x, move_dx) : pend_x;
    pend_y_nxt = (state == COMMIT) ? '0 : accept ? sat_add(pend_y, move_dy) : pend_y;
  end
  // control state, pending deltas and committed position
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state    <= ACCUM;
      pend_x   <= '0;
      pend_y   <= '0;
      vblank_d <= 1'b0;
      pos_x    <= 10'(INIT_X);
      pos_y    <= 10'(INIT_Y);
    end else begin
      state    <= state_nxt;
      pend_x   <= pend_x_nxt;
      pend_y   <= pend_y_nxt;
      vblank_d <= DrawY >= 10'(V_ACTIVE);
      if (state == COMMIT) begin
        pos_x <= upd_x;
        pos_y <= upd_y;
      end
    end
  end
  // pixel path: register address and hit so they line up with the negedge-clocked ROM output
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rom_address <= '0;
      sprite_hit  <= 1'b0;
    end else begin
      rom_address <= in_box ? ADDR_W'({10'd0, oy} * 20'(SPR_W) + 20'(ox)) : '0;
      sprite_hit  <= in_box;
    end
  end
endmodule

// File: tb/tb_cursor_sprite_ctrl.sv
// tb_cursor_sprite_ctrl: directed scoreboard bench for cursor_sprite_ctrl
module tb_cursor_sprite_ctrl;
  logic vga_clk = 0, reset = 1, blank = 0, move_valid = 0;
  logic [9:0] DrawX = 0, DrawY = 0;
  logic signed [5:0] move_dx = 0, move_dy = 0;
  logic move_ready, sprite_hit;
  logic [9:0] rom_address, pos_x, pos_y;
  typedef struct {string tag; logic [31:0] val;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  int mx = 308, my = 224, px = 0, py = 0;

  cursor_sprite_ctrl dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .move_valid(move_valid), .move_ready(move_ready), .move_dx(move_dx), .move_dy(move_dy),
    .rom_address(rom_address), .sprite_hit(sprite_hit), .pos_x(pos_x), .pos_y(pos_y)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed %0d expected entry", obs);
    end else begin
      e = sb.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  function automatic int sat(input int v);
    return v > 1023 ? 1023 : v < -1024 ? -1024 : v;
  endfunction

  function automatic int upd(input int v, input int lim, input int span);
`ifdef CURSOR_WRAP_EN
    return ((v % span) + span) % span;
`else
    return v < 0 ? 0 : v > lim ? lim : v;
`endif
  endfunction

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic pix(input int x, input int y, input bit b);
    int ox, oy;
    bit inb;
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
    ox = (x - mx) & 1023;
    oy = (y - my) & 1023;
    inb = b && ox < 24 && oy < 32 && x < 640;
    push("pix_addr", inb ? oy * 24 + ox : 0);
    push("pix_hit", int'(inb));
    tick();
    pop_chk(32'(rom_address));
    pop_chk(32'(sprite_hit));
  endtask

  task automatic move(input int dx, input int dy);
    move_valid = 1;
    move_dx = 6'(dx);
    move_dy = 6'(dy);
    chk("ready_accum", 32'(move_ready), 1);
    tick();
    move_valid = 0;
    px = sat(px + dx);
    py = sat(py + dy);
  endtask

  task automatic commit();
    DrawY = 10'd480;
    tick();
    chk("ready_commit", 32'(move_ready), 0);
    chk("pos_hold_x", 32'(pos_x), mx);
    mx = upd(mx + px, 616, 640);
    my = upd(my + py, 448, 480);
    px = 0;
    py = 0;
    push("commit_x", mx);
    push("commit_y", my);
    tick();
    pop_chk(32'(pos_x));
    pop_chk(32'(pos_y));
    chk("ready_after", 32'(move_ready), 1);
    DrawY = 10'd100;
    tick();
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_pos_x", 32'(pos_x), 308);
    chk("rst_pos_y", 32'(pos_y), 224);
    chk("rst_addr", 32'(rom_address), 0);
    chk("rst_hit", 32'(sprite_hit), 0);
    chk("rst_ready", 32'(move_ready), 1);
    reset = 0;
    tick();
    pix(308, 224, 1);
    pix(331, 255, 1);
    chk("last_pixel_767", 32'(rom_address), 767);
    pix(320, 230, 1);
    pix(307, 224, 1);
    pix(308, 223, 1);
    pix(308, 224, 0);
    pix(332, 224, 1);
    DrawY = 10'd100;
    tick();
    move(5, -3);
    chk("pos_unchanged", 32'(pos_x), 308);
    commit();
    chk("move_x_313", 32'(pos_x), 313);
    chk("move_y_221", 32'(pos_y), 221);
    pix(313, 221, 1);
    pix(336, 252, 1);
    DrawY = 10'd480;
    move_valid = 1;
    move_dx = 6'sd2;
    move_dy = 6'sd1;
    chk("ready_rise", 32'(move_ready), 1);
    tick();
    px = sat(px + 2);
    py = sat(py + 1);
    chk("ready_commit_held", 32'(move_ready), 0);
    tick();
    mx = upd(mx + px, 616, 640);
    my = upd(my + py, 448, 480);
    px = 0;
    py = 0;
    push("rise_x", mx);
    push("rise_y", my);
    pop_chk(32'(pos_x));
    pop_chk(32'(pos_y));
    chk("ready_after_held", 32'(move_ready), 1);
    tick();
    move_valid = 0;
    px = sat(px + 2);
    py = sat(py + 1);
    chk("held_not_yet", 32'(pos_x), mx);
    DrawY = 10'd100;
    tick();
    commit();
    for (int i = 0; i < 10; i++) move(i < 9 ? 31 : 14, i < 7 ? 31 : 0);
    commit();
    move(31, 31);
    commit();
    for (int i = 0; i < 19; i++) move(i < 18 ? -32 : -30, 0);
    commit();
    move(-32, 0);
    commit();
    for (int i = 0; i < 40; i++) move(31, 0);
    for (int i = 0; i < 20; i++) move(-32, 0);
    commit();
    for (int i = 0; i < 40; i++) move(31, 0);
    commit();
    move(7, 7);
    DrawY = 10'd480;
    tick();
    chk("rst_in_commit_ready", 32'(move_ready), 0);
    reset = 1;
    DrawY = 10'd100;
    tick();
    reset = 0;
    mx = 308;
    my = 224;
    px = 0;
    py = 0;
    chk("rst_mid_x", 32'(pos_x), 308);
    chk("rst_mid_y", 32'(pos_y), 224);
    chk("rst_mid_ready", 32'(move_ready), 1);
    tick();
    commit();
    pix(331, 255, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
